// File: rtl/adder_ring_meas_ctrl_if.sv
// Bus between the measurement sequencer and its surroundings.
// The master side (software / bench) drives the request, configuration,
// ring tap and result_ready. The slave side (the sequencer) drives status,
// the latched configuration and the result handshake.
interface adder_ring_meas_ctrl_if #(
    parameter int COUNT_W = 16,
    parameter int WIN_W   = 16
);
    logic               start;
    logic [WIN_W-1:0]   window_len;
    logic [7:0]         cfg_a;
    logic [7:0]         cfg_xor;
    logic [7:0]         cfg_add;
    logic               busy;
    logic               ring_reset;
    logic [7:0]         input_a;
    logic [7:0]         xor_enable;
    logic [7:0]         add_enable;
    logic               ring_tap;
    logic [COUNT_W-1:0] result;
    logic               result_valid;
    logic               result_ready;
    logic               overflow;

    modport master (
        output start, window_len, cfg_a, cfg_xor, cfg_add, ring_tap, result_ready,
        input  busy, ring_reset, input_a, xor_enable, add_enable,
               result, result_valid, overflow
    );

    modport slave (
        input  start, window_len, cfg_a, cfg_xor, cfg_add, ring_tap, result_ready,
        output busy, ring_reset, input_a, xor_enable, add_enable,
               result, result_valid, overflow
    );
endinterface

// File: rtl/adder_ring_meas_ctrl.sv
// Ring-oscillator adder measurement sequencer.
// IDLE -> SETUP (ring held in reset while the new config settles)
//      -> RUN   (ring released, rising edges of the synchronised tap counted)
//      -> DONE  (count offered on a valid/ready handshake).
// Optional build macro MEAS_OVF_EN: edge count saturates and raises overflow;
// without it the count wraps and overflow is tied low.
module adder_ring_meas_ctrl #(
    parameter int COUNT_W       = 16,
    parameter int WIN_W         = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input logic                    clk,
    input logic                    reset,
    adder_ring_meas_ctrl_if.slave  bus
);
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

    state_t             state;
    logic               tap_meta;
    logic               tap_sync;
    logic               tap_prev;
    logic               rise;
    logic [WIN_W-1:0]   win_cnt;
    logic [SET_W-1:0]   settle_cnt;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] count_nxt;

    // Two-flop synchroniser plus previous-value register for edge detect.
    // prev tracks the synchronised tap every cycle (including all of SETUP),
    // so the first RUN cycle never sees a stale low prev.
    always_ff @(posedge clk) begin
        if (reset) begin
            tap_meta <= 1'b0;
            tap_sync <= 1'b0;
            tap_prev <= 1'b0;
        end else begin
            tap_meta <= bus.ring_tap;
            tap_sync <= tap_meta;
            tap_prev <= tap_sync;
        end
    end

    assign rise = tap_sync & ~tap_prev;

`ifdef MEAS_OVF_EN
    logic ovf_hit;
    logic ovf_q;

    // Saturating increment; an edge arriving at full scale flags overflow.
    always_comb begin
        ovf_hit   = 1'b0;
        count_nxt = count;
        if (rise) begin
            if (&count) ovf_hit   = 1'b1;
            else        count_nxt = count + 1'b1;
        end
    end

    assign bus.overflow = ovf_q;
`else
    assign count_nxt    = count + COUNT_W'(rise);
    assign bus.overflow = 1'b0;
`endif

    // Sequencer FSM; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            bus.busy         <= 1'b0;
            bus.ring_reset   <= 1'b1;
            bus.input_a      <= '0;
            bus.xor_enable   <= '0;
            bus.add_enable   <= '0;
            bus.result       <= '0;
            bus.result_valid <= 1'b0;
            win_cnt          <= '0;
            settle_cnt       <= '0;
            count            <= '0;
`ifdef MEAS_OVF_EN
            ovf_q            <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.input_a    <= bus.cfg_a;
                        bus.xor_enable <= bus.cfg_xor;
                        bus.add_enable <= bus.cfg_add;
                        // A zero window still gives one RUN cycle.
                        win_cnt        <= (bus.window_len == '0) ? WIN_W'(1) : bus.window_len;
                        count          <= '0;
                        settle_cnt     <= SET_W'(SETTLE_CYCLES - 1);
                        bus.busy       <= 1'b1;
                        state          <= SETUP;
`ifdef MEAS_OVF_EN
                        ovf_q          <= 1'b0;
`endif
                    end
                end
                SETUP: begin
                    if (settle_cnt == '0) begin
                        bus.ring_reset <= 1'b0;
                        state          <= RUN;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                RUN: begin
                    count   <= count_nxt;
                    win_cnt <= win_cnt - 1'b1;
`ifdef MEAS_OVF_EN
                    ovf_q   <= ovf_q | ovf_hit;
`endif
                    // Last window cycle: its edge goes straight into result.
                    if (win_cnt == WIN_W'(1)) begin
                        bus.ring_reset   <= 1'b1;
                        bus.result       <= count_nxt;
                        bus.result_valid <= 1'b1;
                        state            <= DONE;
                    end
                end
                DONE: begin
                    if (bus.result_ready) begin
                        bus.result_valid <= 1'b0;
                        bus.busy         <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_ring_meas_ctrl.sv
// Bench for adder_ring_meas_ctrl: one 16-bit counter instance for the main
// scenarios and one 4-bit instance for counter overflow. Expected results are
// queued when a start is driven and compared when the result handshake fires.
module tb_adder_ring_meas_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    adder_ring_meas_ctrl_if #(.COUNT_W(16), .WIN_W(16)) m ();
    adder_ring_meas_ctrl_if #(.COUNT_W(4),  .WIN_W(16)) n ();

    adder_ring_meas_ctrl #(.COUNT_W(16), .WIN_W(16), .SETTLE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .bus(m.slave));
    adder_ring_meas_ctrl #(.COUNT_W(4), .WIN_W(16), .SETTLE_CYCLES(4)) dut_ovf (
        .clk(clk), .reset(reset), .bus(n.slave));

    int errs = 0;
    int checks = 0;
    logic [31:0] q16[$];
    logic [31:0] q4[$];
    int half16 = 0;
    int tc16 = 0;
    bit t4 = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ring taps change on the falling edge, unrelated to DUT sampling.
    always @(negedge clk) begin
        if (half16 == 0) begin
            m.ring_tap = 1'b0;
            tc16 = 0;
        end else begin
            tc16++;
            if (tc16 >= half16) begin
                tc16 = 0;
                m.ring_tap = ~m.ring_tap;
            end
        end
        t4 = ~t4;
        n.ring_tap = t4;
    end

    // Scoreboard: compare on each accepted result.
    always @(negedge clk) begin
        if (!reset && m.result_valid && m.result_ready) begin
            chk("m_pending", 32'(q16.size() > 0), 32'd1);
            if (q16.size() > 0) begin
                logic [31:0] e;
                e = q16.pop_front();
                chk("m_result", 32'(m.result), {16'd0, e[15:0]});
                chk("m_ovf", 32'(m.overflow), {31'd0, e[16]});
            end
        end
        if (!reset && n.result_valid && n.result_ready) begin
            chk("n_pending", 32'(q4.size() > 0), 32'd1);
            if (q4.size() > 0) begin
                logic [31:0] e;
                e = q4.pop_front();
                chk("n_result", 32'(n.result), {28'd0, e[3:0]});
                chk("n_ovf", 32'(n.overflow), {31'd0, e[16]});
            end
        end
    end

    // Called one sample after the start-accept edge; returns cycles from
    // start-high to result_valid and number of cycles with ring released.
    task automatic wait_valid16(input logic [7:0] a_exp, output int lat, output int low, output int a_bad);
        lat = 1;
        low = 0;
        a_bad = 0;
        while (!m.result_valid && lat < 400) begin
            if (!m.ring_reset) low++;
            if (m.input_a !== a_exp) a_bad++;
            tick();
            lat++;
        end
    endtask

    task automatic wait_q4_empty(input string tag);
        int k = 0;
        while (q4.size() != 0 && k < 400) begin
            tick();
            k++;
        end
        chk(tag, 32'(q4.size()), 32'd0);
    endtask

    task automatic wait_q16_empty(input string tag);
        int k = 0;
        while (q16.size() != 0 && k < 400) begin
            tick();
            k++;
        end
        chk(tag, 32'(q16.size()), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, low, a_bad, bad;
        m.start = 0; m.window_len = 0; m.cfg_a = 0; m.cfg_xor = 0; m.cfg_add = 0; m.result_ready = 0;
        n.start = 0; n.window_len = 0; n.cfg_a = 0; n.cfg_xor = 0; n.cfg_add = 0; n.result_ready = 1;

        // Reset state
        reset = 1;
        repeat (3) tick();
        chk("rst_ring_reset", 32'(m.ring_reset), 1);
        chk("rst_busy", 32'(m.busy), 0);
        chk("rst_valid", 32'(m.result_valid), 0);
        chk("rst_cfg", {8'd0, m.input_a, m.xor_enable, m.add_enable}, 0);
        chk("rst_result", 32'(m.result), 0);
        chk("rst_ovf", 32'(m.overflow), 0);
        reset = 0;
        tick();

        // Nominal: 80-cycle window, tap period 8 -> 10 edges
        half16 = 4;
        m.cfg_a = 8'h5A; m.cfg_xor = 8'h01; m.cfg_add = 8'hFF; m.window_len = 80;
        m.start = 1;
        q16.push_back({15'd0, 1'b0, 16'd10});
        tick();
        m.start = 0;
        chk("nom_busy", 32'(m.busy), 1);
        wait_valid16(8'h5A, lat, low, a_bad);
        chk("nom_latency", 32'(lat), 85);
        chk("nom_ring_low", 32'(low), 80);
        chk("nom_input_a", 32'(a_bad), 0);
        chk("nom_cfg", {8'd0, m.input_a, m.xor_enable, m.add_enable}, 32'h5A01FF);

        // Stall with ready low; start pulses with new config must be ignored
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5 || i == 6) begin
                m.start = 1; m.cfg_a = 8'h11; m.window_len = 3;
            end else begin
                m.start = 0;
            end
            if (i == 10) half16 = 0;
            if (!m.result_valid || m.result !== 16'd10 || !m.busy || m.input_a !== 8'h5A) bad++;
            tick();
        end
        m.start = 0;
        chk("stall_stable", 32'(bad), 0);
        chk("stall_input_a", 32'(m.input_a), 32'h5A);
        m.result_ready = 1;
        tick();
        chk("hs_idle_busy", 32'(m.busy), 0);
        chk("hs_idle_valid", 32'(m.result_valid), 0);
        chk("hs_q_drained", 32'(q16.size()), 0);

        // Immediate start, zero window, static tap -> one RUN cycle, result 0
        m.result_ready = 0;
        m.cfg_a = 8'hC3; m.window_len = 0; m.start = 1;
        q16.push_back(32'd0);
        tick();
        m.start = 0;
        chk("zw_accept_busy", 32'(m.busy), 1);
        wait_valid16(8'hC3, lat, low, a_bad);
        chk("zw_latency", 32'(lat), 6);
        chk("zw_ring_low", 32'(low), 1);
        m.result_ready = 1;
        tick();
        wait_q16_empty("zw_drain");

        // Overflow: 4-bit counter, tap toggling every clk, 100-cycle window -> 50 edges
        n.window_len = 100; n.cfg_a = 8'h0F; n.start = 1;
`ifdef MEAS_OVF_EN
        q4.push_back({15'd0, 1'b1, 16'd15});
`else
        q4.push_back({15'd0, 1'b0, 16'd2});
`endif
        tick();
        n.start = 0;
        wait_q4_empty("ovf_done");
        tick();
        n.window_len = 2; n.start = 1;
        q4.push_back({15'd0, 1'b0, 16'd1});
        tick();
        n.start = 0;
        chk("ovf_clr_setup", 32'(n.overflow), 0);
        wait_q4_empty("ovf2_done");

        // Abort during RUN cycle 30; no result may appear afterwards
        half16 = 4;
        m.result_ready = 1;
        m.cfg_a = 8'h77; m.window_len = 80; m.start = 1;
        tick();
        m.start = 0;
        for (int k = 0; k < 20 && m.ring_reset; k++) tick();
        chk("abort_in_run", 32'(m.ring_reset), 0);
        repeat (29) tick();
        reset = 1;
        tick();
        chk("abort_ring_reset", 32'(m.ring_reset), 1);
        chk("abort_busy", 32'(m.busy), 0);
        chk("abort_valid", 32'(m.result_valid), 0);
        chk("abort_cfg", {8'd0, m.input_a, m.xor_enable, m.add_enable}, 0);
        chk("abort_result", 32'(m.result), 0);
        reset = 0;
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            if (m.result_valid || m.busy) bad++;
            tick();
        end
        chk("abort_quiet", 32'(bad), 0);

        // Recovery: window 16, tap period 8 -> 2 edges
        m.window_len = 16; m.cfg_a = 8'h3C; m.start = 1;
        q16.push_back({15'd0, 1'b0, 16'd2});
        tick();
        m.start = 0;
        wait_q16_empty("recover_done");

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/adder_ring_meas_ctrl.md
Name: adder_ring_meas_ctrl

Overview:
Measurement sequencer for the ring-oscillator adder characterisation datapath. It latches a test configuration (adder operand A, per-bit XOR and add enables) and holds the ring in reset while the configuration settles. It then releases the ring for a programmed window of clk cycles and counts rising edges of one synchronised ring tap. It reports the count through a valid/ready result handshake, so software can derive adder delay from oscillation frequency.

Parameters:
COUNT_W, 16, width of edge counter and result
WIN_W, 16, width of window_len
SETTLE_CYCLES, 4, cycles ring is held in reset with new config before release (min 1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  request a measurement; sampled only in IDLE
window_len  input  WIN_W  RUN duration in clk cycles; 0 treated as 1
cfg_a  input  8  operand A to apply
cfg_xor  input  8  xor_enable pattern to apply
cfg_add  input  8  add_enable pattern to apply
busy  output  1  high in SETUP, RUN, DONE
ring_reset  output  1  drives datapath reset; high except in RUN
input_a  output  8  latched cfg_a
xor_enable  output  8  latched cfg_xor
add_enable  output  8  latched cfg_add
ring_tap  input  1  one bit of datapath outputs; asynchronous to clk
result  output  COUNT_W  edge count of last measurement
result_valid  output  1  result available
result_ready  input  1  consumer accepts result
overflow  output  1  counter saturated (only with MEAS_OVF_EN; otherwise tied 0)

Behaviour:
- Interface: one clock; reset is synchronous and active-high; clock port clk, reset port reset.
- Reset values: busy=0, ring_reset=1, input_a/xor_enable/add_enable=0, result=0, result_valid=0, overflow=0, FSM=IDLE, counters=0.
- reset mid-operation: abort any state next edge; no result produced; outputs return to reset values.
- ring_tap passes through 2-flop synchroniser running every cycle, then a prev register for rising-edge detect (sync=1, prev=0).
- FSM states:
  - IDLE: busy=0, ring_reset=1. start=1 -> latch cfg_a/cfg_xor/cfg_add onto outputs; latch max(window_len,1) into window counter; clear edge count; go SETUP.
  - SETUP: busy=1, ring_reset=1, config stable. Lasts exactly SETTLE_CYCLES cycles. prev is loaded with the synchronised tap on every SETUP cycle, so no spurious edge at entry to RUN. Then go RUN.
  - RUN: ring_reset=0. Each cycle a rising edge is detected, count increments. Window counter decrements; RUN lasts exactly the latched window length. On the last RUN cycle the final edge is included. Then go DONE with result<=count.
  - DONE: ring_reset=1, result_valid=1, result stable. result_valid&&result_ready -> IDLE next cycle, result_valid=0. result holds its value until the next DONE entry.
- start is ignored outside IDLE. cfg_*/window_len changes outside IDLE have no effect.
- Latency start->result_valid: 1 + SETTLE_CYCLES + window cycles.
- Back-to-back operation: start may be high in the IDLE cycle immediately after a handshake.
- Count arithmetic: unsigned COUNT_W. Overflow handling is set by the optional feature.

Optional Feature:
Macro MEAS_OVF_EN.
- Defined: count saturates at 2^COUNT_W-1. overflow is set when an increment is attempted at max. overflow is valid with result in DONE and clears on entry to SETUP.
- Undefined: count wraps modulo 2^COUNT_W; overflow is constant 0; no saturation logic.

Test Plan:
- Reset check: assert reset 3 cycles -> ring_reset=1, busy=0, result_valid=0, all config outputs 0x00.
- Nominal measurement: SETTLE_CYCLES=4, cfg_a=0x5A, cfg_xor=0x01, cfg_add=0xFF, window_len=80, ring_tap toggling every 4 clk -> ring_reset low exactly 80 cycles; result=10; result_valid rises 85 cycles after start accept; input_a=0x5A throughout.
- Handshake and stall: hold result_ready=0 for 20 cycles -> result_valid and result=10 stable, busy=1, start pulses ignored. Ready=1 -> IDLE next cycle; immediate start accepted.
- Zero window: window_len=0, tap static 0 -> RUN lasts 1 cycle; result=0.
- Overflow: COUNT_W=4, tap toggling every clk, window_len=100 -> with MEAS_OVF_EN result=15, overflow=1; without result=2 (50 mod 16), overflow=0.
- Abort: assert reset during RUN cycle 30 -> next cycle ring_reset=1, busy=0, result_valid never asserts. Subsequent measurement with window_len=16 and tap period 8 -> result=2.
